// File: rtl/seg_scan_ctrl_if.sv
// Value handshake bundle for seg_scan_ctrl.
//   value     : binary number to display (BIN_W bits)
//   value_vld : value is valid this cycle
//   value_rdy : converter idle; value accepted when vld & rdy
interface seg_scan_ctrl_if #(
  parameter int unsigned BIN_W = 32
);
  logic [BIN_W-1:0] value;
  logic             value_vld;
  logic             value_rdy;

  modport master (output value, output value_vld, input value_rdy);
  modport slave  (input value, input value_vld, output value_rdy);
endinterface

// File: rtl/seg_scan_ctrl.sv
// Multiplexed common-anode 7-segment driver with sequential binary-to-BCD
// conversion, leading-zero blanking, decimal points and overflow dashes.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : value / value_vld / value_rdy handshake (slave side)
//   lzb_en     : enable leading-zero blanking
//   dp_mask    : per-digit decimal point request, 1 = lit, sampled live
//   shift      : active-low one-hot digit select, bit 0 = least significant
//   oData      : segments {g,f,e,d,c,b,a}, active-low
//   dp         : decimal point, active-low
module seg_scan_ctrl #(
  parameter int unsigned DIGITS  = 8,
  parameter int unsigned BIN_W   = 32,
  parameter int unsigned CLK_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  seg_scan_ctrl_if.slave    bus,
  input  logic              lzb_en,
  input  logic [DIGITS-1:0] dp_mask,
  output logic [DIGITS-1:0] shift,
  output logic [6:0]        oData,
  output logic              dp
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned DIV_W = $clog2(CLK_DIV);

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Largest value that fits in DIGITS decimal digits
  function automatic longint unsigned max_disp();
    longint unsigned p;
    p = 64'd1;
    for (int i = 0; i < int'(DIGITS); i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

  localparam longint unsigned LIMIT = max_disp();

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

  state_t            state_q;
  logic              rdy_q;
  logic [BIN_W-1:0]  sh_q;
  logic [BCD_W-1:0]  bcd_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ovf_pend_q;
  logic [BCD_W-1:0]  disp_q;
  logic              ovf_q;

  logic [DIV_W-1:0]  div_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DIGITS-1:0] shift_q;
  logic [6:0]        seg_q;
  logic              dp_q;

  logic [BCD_W-1:0]  bcd_adj;
  logic [BCD_W-1:0]  bcd_d;
  logic [BIN_W-1:0]  sh_d;

  // One shift-add-3 iteration: adjust nibbles >= 5, then shift in the next MSB
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_d = {bcd_adj[BCD_W-2:0], sh_q[BIN_W-1]};
    sh_d  = sh_q << 1;
  end

  // Converter FSM; the display register updates atomically in S_DONE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rdy_q      <= 1'b0;
      sh_q       <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      disp_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          rdy_q <= 1'b1;
          if (bus.value_vld && rdy_q) begin
            sh_q       <= BIN_W'(bus.value);
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= (64'(bus.value) > LIMIT);
            rdy_q      <= 1'b0;
            state_q    <= S_CONV;
          end
        end
        S_CONV: begin
          bcd_q <= bcd_d;
          sh_q  <= sh_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(BIN_W - 1)) state_q <= S_DONE;
        end
        S_DONE: begin
          disp_q  <= bcd_q;
          ovf_q   <= ovf_pend_q;
          rdy_q   <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  logic [IDX_W-1:0] idx_nxt;
  logic [IDX_W-1:0] msnz;
  logic [3:0]       cur_bcd;
  logic             cur_dp;
  logic [6:0]       seg_nxt;
  logic [DIGITS-1:0] shift_nxt;

  // Content of the digit that becomes active on the next tick
  always_comb begin
    idx_nxt   = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    msnz      = '0;
    cur_bcd   = '0;
    cur_dp    = 1'b0;
    shift_nxt = '1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (disp_q[4*i +: 4] != 4'd0) msnz = IDX_W'(i);
      if (idx_nxt == IDX_W'(i)) begin
        cur_bcd      = disp_q[4*i +: 4];
        cur_dp       = dp_mask[i];
        shift_nxt[i] = 1'b0;
      end
    end
    if (ovf_q)                         seg_nxt = SEG_DASH;
    else if (lzb_en && idx_nxt > msnz) seg_nxt = SEG_BLANK;
    else                               seg_nxt = seg7(cur_bcd);
  end

  // Digit-slot divider and registered scan outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q   <= '0;
      idx_q   <= '0;
      shift_q <= '1;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
    end else if (div_q == DIV_W'(CLK_DIV - 1)) begin
      div_q   <= '0;
      idx_q   <= idx_nxt;
      shift_q <= shift_nxt;
      seg_q   <= seg_nxt;
      dp_q    <= ~cur_dp;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  assign bus.value_rdy = rdy_q;
  assign shift         = shift_q;
  assign oData         = seg_q;
  assign dp            = dp_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DIGITS=4, BIN_W=16, CLK_DIV=4.
module tb_seg_scan_ctrl;

  localparam int unsigned DIGITS  = 4;
  localparam int unsigned BIN_W   = 16;
  localparam int unsigned CLK_DIV = 4;

  logic              clk;
  logic              rst_n;
  logic              lzb_en;
  logic [DIGITS-1:0] dp_mask;
  logic [DIGITS-1:0] shift;
  logic [6:0]        oData;
  logic              dp;

  int total;
  int bad;

  logic [6:0] cap_seg [DIGITS];
  logic       cap_dp  [DIGITS];

  seg_scan_ctrl_if #(.BIN_W(BIN_W)) bus ();

  seg_scan_ctrl #(.DIGITS(DIGITS), .BIN_W(BIN_W), .CLK_DIV(CLK_DIV)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .lzb_en  (lzb_en),
    .dp_mask (dp_mask),
    .shift   (shift),
    .oData   (oData),
    .dp      (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Records segments and dp for each digit over one full frame
  task automatic capture_frame();
    logic [DIGITS-1:0] pat;
    for (int k = 0; k < int'(DIGITS); k++) begin
      cap_seg[k] = 'x;
      cap_dp[k]  = 1'bx;
    end
    repeat (5) @(negedge clk);
    repeat (DIGITS * CLK_DIV) begin
      @(negedge clk);
      for (int k = 0; k < int'(DIGITS); k++) begin
        pat = '1;
        pat[k] = 1'b0;
        if (shift === pat) begin
          cap_seg[k] = oData;
          cap_dp[k]  = dp;
        end
      end
    end
  endtask

  // Starts a transfer and returns how many sampled cycles value_rdy stayed low
  task automatic send(input logic [BIN_W-1:0] v, output int lowcnt);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.value_rdy !== 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    bus.value     = v;
    bus.value_vld = 1'b1;
    @(negedge clk);
    bus.value_vld = 1'b0;
    lowcnt = 0;
    while (bus.value_rdy !== 1'b1 && lowcnt < 200) begin
      lowcnt++;
      @(negedge clk);
    end
  endtask

  task automatic check_frame(input string name, input logic [6:0] e3, input logic [6:0] e2,
                             input logic [6:0] e1, input logic [6:0] e0);
    logic [6:0] exp_seg [DIGITS];
    exp_seg[0] = e0; exp_seg[1] = e1; exp_seg[2] = e2; exp_seg[3] = e3;
    capture_frame();
    for (int k = 0; k < int'(DIGITS); k++) begin
      total++;
      if (cap_seg[k] !== exp_seg[k]) begin
        bad++;
        $display("FAIL %s digit%0d: oData got %b expected %b", name, k, cap_seg[k], exp_seg[k]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (shift !== 4'b1111 || oData !== 7'h7F || dp !== 1'b1 || bus.value_rdy !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: shift=%b oData=%h dp=%b rdy=%b expected 1111 7f 1 0",
               shift, oData, dp, bus.value_rdy);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_scan();
    logic [3:0] exp_shift;
    logic [6:0] exp_seg;
    int idx;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) begin
        total++;
        if (bus.value_rdy !== 1'b1) begin
          bad++;
          $display("FAIL rdy_after_reset: got %b expected 1", bus.value_rdy);
        end
      end
      if (c < 4) begin
        exp_shift = 4'b1111;
        exp_seg   = 7'h7F;
      end else begin
        idx = (c / 4) % 4;
        exp_shift = 4'b1111;
        exp_shift[idx] = 1'b0;
        exp_seg   = 7'h40;
      end
      total++;
      if (shift !== exp_shift || oData !== exp_seg || dp !== 1'b1) begin
        bad++;
        $display("FAIL scan c=%0d: shift=%b oData=%h dp=%b expected %b %h 1",
                 c, shift, oData, dp, exp_shift, exp_seg);
      end
    end
  endtask

  task automatic test_convert();
    int lowcnt;
    send(16'd1234, lowcnt);
    total++;
    if (lowcnt != 17) begin
      bad++;
      $display("FAIL rdy_low_cycles: got %0d expected 17", lowcnt);
    end
    check_frame("bcd_1234", 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001);
  endtask

  task automatic test_lzb();
    int lowcnt;
    lzb_en = 1'b1;
    send(16'd7, lowcnt);
    check_frame("lzb_on_7", 7'h7F, 7'h7F, 7'h7F, 7'b1111000);
    lzb_en = 1'b0;
    check_frame("lzb_off_7", 7'h40, 7'h40, 7'h40, 7'b1111000);
    lzb_en = 1'b1;
    send(16'd0, lowcnt);
    check_frame("lzb_on_0", 7'h7F, 7'h7F, 7'h7F, 7'h40);
    lzb_en = 1'b0;
  endtask

  task automatic test_overflow();
    int lowcnt;
    send(16'd10000, lowcnt);
    check_frame("ovf_10000", 7'h3F, 7'h3F, 7'h3F, 7'h3F);
    send(16'd9999, lowcnt);
    check_frame("max_9999", 7'h10, 7'h10, 7'h10, 7'h10);
  endtask

  task automatic test_busy_ignore();
    int n;
    @(negedge clk);
    bus.value     = 16'd321;
    bus.value_vld = 1'b1;
    @(negedge clk);
    bus.value     = 16'd55;
    repeat (6) @(negedge clk);
    bus.value_vld = 1'b0;
    n = 0;
    while (bus.value_rdy !== 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    total++;
    if (bus.value_rdy !== 1'b1) begin
      bad++;
      $display("FAIL busy_rdy_timeout: rdy=%b expected 1", bus.value_rdy);
    end
    check_frame("busy_ignore", 7'h40, 7'b0110000, 7'b0100100, 7'b1111001);
  endtask

  task automatic test_reset_midconv();
    @(negedge clk);
    bus.value     = 16'd88;
    bus.value_vld = 1'b1;
    @(negedge clk);
    bus.value_vld = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if (bus.value_rdy !== 1'b0 || shift !== 4'b1111 || oData !== 7'h7F) begin
      bad++;
      $display("FAIL midconv_reset: rdy=%b shift=%b oData=%h expected 0 1111 7f",
               bus.value_rdy, shift, oData);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (bus.value_rdy !== 1'b1 || shift !== 4'b1111) begin
      bad++;
      $display("FAIL midconv_release: rdy=%b shift=%b expected 1 1111", bus.value_rdy, shift);
    end
    check_frame("after_abort", 7'h40, 7'h40, 7'h40, 7'h40);
  endtask

  task automatic test_dp();
    logic exp_dp;
    dp_mask = 4'b0100;
    capture_frame();
    for (int k = 0; k < int'(DIGITS); k++) begin
      exp_dp = (k == 2) ? 1'b0 : 1'b1;
      total++;
      if (cap_dp[k] !== exp_dp) begin
        bad++;
        $display("FAIL dp_digit%0d: got %b expected %b", k, cap_dp[k], exp_dp);
      end
    end
    dp_mask = '0;
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    rst_n         = 1'b0;
    lzb_en        = 1'b0;
    dp_mask       = '0;
    bus.value     = '0;
    bus.value_vld = 1'b0;
    test_reset();
    test_scan();
    test_convert();
    test_lzb();
    test_overflow();
    test_busy_ignore();
    test_reset_midconv();
    test_dp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
